// File: rtl/byte_mem_responder.sv
// Byte-array read responder with configurable response latency, request
// backpressure injection and a host preload write port.
module byte_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LAT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_rsp_vld,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    input  logic [LAT_WIDTH-1:0]  lat_cfg,
    input  logic                  rdy_mask,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [15:0]           req_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [LAT_WIDTH-1:0]  cnt;
    logic [LAT_WIDTH-1:0]  next_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  accept_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Backing store: host preload writes, not affected by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // FSM state, latency countdown and captured request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            addr_q <= next_addr;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_addr  = addr_q;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (m_req_vld && m_req_rdy) begin
                    accept_c  = 1'b1;
                    next_addr = m_req_addr;
                    if (lat_cfg == '0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = lat_cfg - LAT_WIDTH'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - LAT_WIDTH'(1);
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered outputs; ready stays low until the cycle after the response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_rdy  <= 1'b0;
            m_rsp_vld  <= 1'b0;
            m_rsp_data <= '0;
            req_count  <= '0;
        end else begin
            m_req_rdy <= (state == IDLE) && (next_state == IDLE) && !rdy_mask;
            m_rsp_vld <= (state == RESP);
            if (state == RESP) begin
                m_rsp_data <= mem[addr_q];
            end
            if (accept_c) begin
                req_count <= req_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/byte_mem_responder.md
BYTE_MEM_RESPONDER -- requirements
Module: byte_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default ADDR_WIDTH from bronco_params, request address width; array depth 2**ADDR_WIDTH bytes.
REQ-002 Parameter DATA_WIDTH, default DATA_WIDTH from bronco_params (8), response data width.
REQ-003 Parameter LAT_WIDTH, default 4, width of the latency configuration.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 m_req_vld  in  1  read request valid from the initiator.
REQ-007 m_req_rdy  out  1  responder can accept a request (registered).
REQ-008 m_req_addr  in  ADDR_WIDTH  byte address of the request.
REQ-009 m_rsp_vld  out  1  one-cycle read-response pulse (registered; no rsp ready).
REQ-010 m_rsp_data  out  DATA_WIDTH  read data, valid while m_rsp_vld=1.
REQ-011 lat_cfg  in  LAT_WIDTH  extra response latency in cycles, sampled at accept.
REQ-012 rdy_mask  in  1  1 = suppress m_req_rdy (backpressure injection).
REQ-013 wr_en  in  1  host preload write strobe.
REQ-014 wr_addr  in  ADDR_WIDTH  host write address.
REQ-015 wr_data  in  DATA_WIDTH  host write data.
REQ-016 req_count  out  16  number of accepted requests since reset, wraps at 2**16.

Function
REQ-017 Request accepted on a rising edge where m_req_vld=1 and m_req_rdy=1; m_req_addr and lat_cfg are captured at that edge.
REQ-018 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-019 IDLE -> WAIT on accept with captured lat_cfg>0 (countdown loaded with lat_cfg-1); IDLE -> RESP on accept with lat_cfg=0.
REQ-020 WAIT: countdown decrements each cycle; WAIT -> RESP when countdown=0.
REQ-021 RESP: m_rsp_vld=1 for exactly one cycle, m_rsp_data = array[captured addr]; RESP -> IDLE unconditionally.
REQ-022 Latency: accept at edge T -> m_rsp_vld high in the cycle after edge T+1+lat_cfg (lat_cfg=0: response visible one cycle after accept edge).
REQ-023 At most one request outstanding; m_req_rdy is driven from next-state so m_req_rdy=1 only while state=IDLE and rdy_mask=0 on the previous edge.
REQ-024 m_req_rdy=0 during WAIT and RESP; first re-assertion possible in the cycle after the m_rsp_vld cycle.
REQ-025 m_req_vld while m_req_rdy=0 is ignored; initiator holds addr until accept; no request is lost or duplicated.
REQ-026 m_rsp_data holds last value when m_rsp_vld=0.
REQ-027 Host write: wr_en=1 writes wr_data to array[wr_addr] at the edge; accepted in any state, independent of the request path.
REQ-028 Array read happens in the cycle the response is registered; a write to the same address on that same edge is not visible (old data returned); a write on any earlier edge after accept is visible.
REQ-029 req_count increments by 1 per accept; wraps 16'hFFFF -> 0.
REQ-030 lat_cfg changes after accept do not affect the pending request.

Reset
REQ-031 rst_n=0 asynchronously forces: state=IDLE, m_req_rdy=0, m_rsp_vld=0, m_rsp_data=0, countdown=0, req_count=0.
REQ-032 Reset during WAIT or RESP drops the pending request; no m_rsp_vld after release.
REQ-033 Array contents are not cleared by reset; content after power-up is undefined until written.
REQ-034 First m_req_rdy=1 no earlier than the cycle after the first rising edge with rst_n=1.

Verification
REQ-035 Preload array[0x10]=0x5A, lat_cfg=0, request 0x10 -> m_rsp_vld one cycle after accept, data 0x5A, m_req_rdy low that cycle.
REQ-036 lat_cfg=3, request 0x20 (preloaded 0x11) -> m_rsp_vld exactly 4 cycles after accept edge, one-cycle pulse, data 0x11.
REQ-037 m_req_vld held high with rdy_mask toggling, addresses 0x80..0x83 preloaded 1..4 -> responses 1,2,3,4 in order, req_count=4, never two outstanding.
REQ-038 Pending read of 0x30 (old 0x00), wr_en to 0x30 with 0x77 on response edge -> data 0x00; repeat with write one cycle earlier -> data 0x77.
REQ-039 Assert rst_n=0 during WAIT (lat_cfg=5) -> m_rsp_vld stays 0, req_count=0, m_req_rdy=0; after release new request served normally and preloaded contents intact.
REQ-040 Connected to gpu_top with random lat_cfg 0..3 and random rdy_mask, W at 0x10, X at 0x80 (identity, [1,2,3,4]) -> results 1,2,3,4.
